s_term_edge_capture: RTL

- Edge logic-analyser that taps the 52 south-arriving routing wires of a bottom-row terminal tile: S1END[3:0], S2MID[7:0], S2END[7:0], S4END[15:0], SS4END[15:0], concatenated in that order, LSB first.
- Samples the bus every UserCLK cycle into a circular buffer. On a masked-compare trigger it freezes a window of pre- and post-trigger samples.
- Streams the frozen window out oldest-first over a valid/ready port.
- Sits directly beside the south terminal switch matrix and consumes the same wires the matrix loops back north. Used for fabric bring-up and routing debug.

---
 rtl/s_term_edge_capture.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/s_term_edge_capture.sv
// s_term_edge_capture
//
// Logic analyser for the 52 south-arriving routing wires of a bottom-row
// terminal tile. It registers the wires every cycle, keeps a circular
// history buffer and freezes a window of pre- and post-trigger samples
// when a masked compare matches. The frozen window is streamed out
// oldest-first over a valid/ready port.
//
// Ports:
//   UserCLK       sole clock, rising edge
//   RESET         asynchronous active-high reset
//   wires_i       tapped edge wires {SS4END,S4END,S2END,S2MID,S1END}, LSB first
//   arm_i         one-cycle pulse that starts a capture (IDLE only)
//   abort_i       forces IDLE from any state (highest priority)
//   trig_mask_i   1 = bit takes part in the trigger compare
//   trig_value_i  required value on the masked bits
//   pretrig_i     samples kept before the trigger sample, latched on arm
//   rd_valid_o    read word valid
//   rd_ready_i    consumer accepts the read word
//   rd_data_o     buffered sample
//   rd_last_o     final word of the window
//   busy_o        high in every state except IDLE
//   triggered_o   sticky trigger flag, cleared by arm or reset
module s_term_edge_capture #(
    parameter int WIDTH = 52,
    parameter int DEPTH = 16,
    parameter int PW    = 4
) (
    input  logic             UserCLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] wires_i,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] trig_mask_i,
    input  logic [WIDTH-1:0] trig_value_i,
    input  logic [PW-1:0]    pretrig_i,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_last_o,
    output logic             busy_o,
    output logic             triggered_o
);

    localparam int          AW     = $clog2(DEPTH);
    localparam int unsigned MAXPRE = DEPTH - 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WAIT,
        S_POST,
        S_READ
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] sample_q;
    logic [WIDTH-1:0] mem_reg [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] cnt_reg;
    logic [AW-1:0] pre_reg;
    logic [AW-1:0] post_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_cnt_reg;

    logic [AW-1:0] pre_clamped;
    logic [AW-1:0] cnt_inc;
    logic [AW-1:0] rd_ptr_inc;
    logic [AW-1:0] rd_cnt_inc;

    logic [WIDTH-1:0] bit_miss;
    logic             trig_hit;

    logic mem_we;
    logic arm_go;
    logic fill_done;
    logic trig_fire;
    logic rd_prime;
    logic rd_xfer;

    // Per-bit masked mismatch; the trigger matches when no masked bit differs.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cmp
            assign bit_miss[gi] = (sample_q[gi] ^ trig_value_i[gi]) & trig_mask_i[gi];
        end
    endgenerate

    assign trig_hit   = ~|bit_miss;
    assign cnt_inc    = cnt_reg + AW'(1);
    assign rd_ptr_inc = rd_ptr_reg + AW'(1);
    assign rd_cnt_inc = rd_cnt_reg + AW'(1);
    assign busy_o     = (state_reg != S_IDLE);

    // Keep the pre-trigger count within the buffer so at least the trigger
    // sample itself fits in the window.
    always_comb begin
        pre_clamped = AW'(pretrig_i);
        if (32'(pretrig_i) > MAXPRE) begin
            pre_clamped = AW'(MAXPRE);
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_next = state_reg;
        mem_we     = 1'b0;
        arm_go     = 1'b0;
        fill_done  = 1'b0;
        trig_fire  = 1'b0;
        rd_prime   = 1'b0;
        rd_xfer    = 1'b0;
        if (abort_i) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (arm_i) begin
                        arm_go     = 1'b1;
                        state_next = (pre_clamped == '0) ? S_WAIT : S_FILL;
                    end
                end
                S_FILL: begin
                    // The compare is deliberately not looked at here, so a
                    // match on the last fill cycle is not a trigger.
                    mem_we = 1'b1;
                    if (cnt_inc == pre_reg) begin
                        fill_done  = 1'b1;
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    mem_we = 1'b1;
                    if (trig_hit) begin
                        trig_fire  = 1'b1;
                        state_next = (post_reg == '0) ? S_READ : S_POST;
                    end
                end
                S_POST: begin
                    mem_we = 1'b1;
                    if (cnt_inc == post_reg) begin
                        state_next = S_READ;
                    end
                end
                S_READ: begin
                    // First READ cycle fetches the oldest word; afterwards
                    // each accepted word fetches the next one.
                    if (!rd_valid_o) begin
                        rd_prime = 1'b1;
                    end else if (rd_ready_i) begin
                        rd_xfer = 1'b1;
                        if (rd_last_o) begin
                            state_next = S_IDLE;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge UserCLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // History buffer: contents are deliberately not reset.
    always_ff @(posedge UserCLK) begin
        if (mem_we) begin
            mem_reg[wr_ptr_reg] <= sample_q;
        end
    end

    // Capture-side datapath.
    always_ff @(posedge UserCLK or posedge RESET) begin
        if (RESET) begin
            sample_q    <= '0;
            wr_ptr_reg  <= '0;
            cnt_reg     <= '0;
            pre_reg     <= '0;
            post_reg    <= '0;
            triggered_o <= 1'b0;
        end else begin
            sample_q <= wires_i;
            if (arm_go) begin
                pre_reg     <= pre_clamped;
                post_reg    <= AW'(MAXPRE) - pre_clamped;
                wr_ptr_reg  <= '0;
                cnt_reg     <= '0;
                triggered_o <= 1'b0;
            end else begin
                if (mem_we) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                if (fill_done) begin
                    cnt_reg <= '0;
                end else if (mem_we && state_reg != S_WAIT) begin
                    cnt_reg <= cnt_inc;
                end
                if (trig_fire) begin
                    triggered_o <= 1'b1;
                end
            end
        end
    end

    // Read-side datapath. After the final write wr_ptr_reg points at the
    // oldest sample, which is where streaming starts.
    always_ff @(posedge UserCLK or posedge RESET) begin
        if (RESET) begin
            rd_ptr_reg <= '0;
            rd_cnt_reg <= '0;
            rd_valid_o <= 1'b0;
            rd_last_o  <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            if (abort_i) begin
                rd_valid_o <= 1'b0;
                rd_last_o  <= 1'b0;
            end else if (rd_prime) begin
                rd_ptr_reg <= wr_ptr_reg;
                rd_cnt_reg <= '0;
                rd_valid_o <= 1'b1;
                rd_last_o  <= 1'b0;
                rd_data_o  <= mem_reg[wr_ptr_reg];
            end else if (rd_xfer) begin
                if (rd_last_o) begin
                    rd_valid_o <= 1'b0;
                    rd_last_o  <= 1'b0;
                end else begin
                    rd_ptr_reg <= rd_ptr_inc;
                    rd_cnt_reg <= rd_cnt_inc;
                    rd_last_o  <= (rd_cnt_inc == LAST_IDX);
                    rd_data_o  <= mem_reg[rd_ptr_inc];
                end
            end
        end
    end

endmodule
